retire_unit: RTL and testbench
==============================

# retire_unit

Retirement stage directly downstream of `reorder_buffer`. It consumes the ROB commit handshake and maintains the retirement (architectural) RAT. It queues each committed instruction's superseded physical register and returns it to the `rename` free list through that block's `retire_valid`/`retire_phys_reg` port. It also emits a registered commit trace for debug.

## Interface
Parameters:
- `FREE_Q_DEPTH`, 4: entries in the freed-register return queue; power of two, ≥2.
- `PHYS_W`, 6: physical register index width (64 physical registers).
- `ARCH_W`, 5: architectural register index width (32 registers).

Ports:
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: synchronous, active-high.
- `commit_valid` input 1: ROB head entry is ready to retire.
- `commit_ready` output 1: retire_unit accepts the head entry this cycle.
- `commit_arch_rd` input ARCH_W: architectural destination; 0 = no destination.
- `commit_dest` input PHYS_W: new physical destination (ROB `commit_dest`).
- `free_oldDest` input PHYS_W: superseded physical register (ROB `free_oldDest`).
- `commit_value` input 32: result value.
- `retire_valid` output 1: freed register offered to rename free list.
- `retire_phys_reg` output PHYS_W: register being freed.
- `free_ready` input 1: free list accepts `retire_phys_reg` this cycle.
- `rrat_rd_idx` input ARCH_W: RRAT read index for recovery/debug.
- `rrat_rd_phys` output PHYS_W: combinational RRAT[`rrat_rd_idx`].
- `trace_valid` output 1, `trace_rd` output ARCH_W, `trace_value` output 32: registered commit trace.

## Operation
- Accept = `commit_valid && commit_ready`.
- `commit_ready` = free queue count < FREE_Q_DEPTH. It depends only on registered count; there is no same-cycle bypass when full.
- On accept with `commit_arch_rd != 0`:
  - RRAT[`commit_arch_rd`] ← `commit_dest`.
  - Push `free_oldDest` into the free queue.
- On accept with `commit_arch_rd == 0`: RRAT and queue are unchanged. RRAT[0] stays 0 permanently.
- Free queue is FIFO:
  - `retire_valid` = queue non-empty.
  - `retire_phys_reg` = queue head.
  - Pop when `retire_valid && free_ready`.
- Push and pop in the same cycle: count unchanged, head advances, pointers wrap modulo FREE_Q_DEPTH.
- Trace: on every accept, including rd=0, the cycle after drives `trace_valid`=1 with `trace_rd`/`trace_value`. Otherwise `trace_valid`=0.
- `rrat_rd_phys` reflects RRAT state before this cycle's update; there is no write-to-read bypass.

## Timing
- Reset values:
  - RRAT[i] = i for i = 0..31.
  - Queue empty (count 0, pointers 0).
  - `commit_ready`=1, `retire_valid`=0, `retire_phys_reg`=0.
  - `trace_valid`=0, `trace_rd`=0, `trace_value`=0.
- Reset mid-operation: all queued frees are discarded and the RRAT returns to identity. Rename and ROB are reset in the same cycle.
- Latency from accept in cycle N:
  - RRAT visible on `rrat_rd_phys` in N+1.
  - `retire_valid` for that entry earliest in N+1.
  - Trace in N+1.
- Throughput: 1 commit per cycle while `free_ready` stays high.
- When full: `commit_ready`=0 until a pop is registered, so it rises one cycle after the first pop.
- `commit_ready` must not depend combinationally on `commit_valid`.

## Configuration
- `RETIRE_PERF_CNT_EN` defined:
  - Adds output `retired_count` (32 bits, reset 0), incremented by 1 on every accept; wraps at 2^32.
  - Adds output `free_stall_count` (32 bits, reset 0), incremented each cycle `retire_valid && !free_ready`.
- Undefined: both ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package `ooo_pkg` holds PHYS_W, ARCH_W, NUM_ARCH_REGS=32 and NUM_PHYS_REGS=64. Rename and ROB import the same constants.
- Sub-module `free_return_fifo`: parameterised FIFO with push/pop/full/empty/head and no other logic.
- RRAT array, accept logic, trace registers and optional counters live in `retire_unit`.

## Test plan
- Reset, then sweep `rrat_rd_idx` 0..31 -> `rrat_rd_phys`=idx, `commit_ready`=1, `retire_valid`=0.
- Accept rd=1, dest=32, old=1 with `free_ready`=1 -> next cycle: RRAT[1]=32, `retire_valid`=1, `retire_phys_reg`=1, `trace_rd`=1; the cycle after: `retire_valid`=0.
- Accept rd=0, dest=40, old=5 -> RRAT unchanged, no `retire_valid`, `trace_valid`=1 with `trace_rd`=0.
- Hold `free_ready`=0 and commit 5 back-to-back (rd=1..5, old=1..5):
  - 4 accepted, `commit_ready`=0 on the 5th.
  - Raise `free_ready` -> pops 1,2,3,4 in order; 5th accepted one cycle after the first pop.
- Sustained commit with `free_ready`=1 for 10 cycles -> `commit_ready` stays 1, frees emerge one per cycle in order, count across wrap is correct.
- Fill the queue with 3 entries, then assert `reset` -> next cycle `retire_valid`=0 and RRAT is identity. With `RETIRE_PERF_CNT_EN`, `retired_count`=0.

Source files
------------

// File: rtl/ooo_pkg.sv
// Shared out-of-order core constants used by rename, reorder_buffer and retire_unit.
package ooo_pkg;

  localparam int PHYS_W        = 6;
  localparam int ARCH_W        = 5;
  localparam int NUM_ARCH_REGS = 32;
  localparam int NUM_PHYS_REGS = 64;

  typedef logic [PHYS_W-1:0] phys_reg_t;
  typedef logic [ARCH_W-1:0] arch_reg_t;

endpackage

// File: rtl/retire_unit_if.sv
// Commit handshake from the ROB plus freed-register return to the rename free list.
interface retire_unit_if #(
  parameter int PHYS_W = ooo_pkg::PHYS_W,
  parameter int ARCH_W = ooo_pkg::ARCH_W
);

  logic              commit_valid;
  logic              commit_ready;
  logic [ARCH_W-1:0] commit_arch_rd;
  logic [PHYS_W-1:0] commit_dest;
  logic [PHYS_W-1:0] free_oldDest;
  logic [31:0]       commit_value;

  logic              retire_valid;
  logic [PHYS_W-1:0] retire_phys_reg;
  logic              free_ready;

  // Master is the ROB/free-list side, slave is the retire unit.
  modport master (
    output commit_valid, commit_arch_rd, commit_dest, free_oldDest, commit_value, free_ready,
    input  commit_ready, retire_valid, retire_phys_reg
  );

  modport slave (
    input  commit_valid, commit_arch_rd, commit_dest, free_oldDest, commit_value, free_ready,
    output commit_ready, retire_valid, retire_phys_reg
  );

endinterface

// File: rtl/retire_unit_fifo.sv
// free_return_fifo: power-of-two FIFO holding superseded physical registers awaiting return.
module free_return_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately left unreset; validity comes from count, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/retire_unit.sv
// retire_unit: maintains the retirement RAT, returns superseded registers, emits a commit trace.
// Optional performance counters are built when RETIRE_PERF_CNT_EN is defined.
module retire_unit
  import ooo_pkg::NUM_ARCH_REGS;
#(
  parameter int FREE_Q_DEPTH = 4,
  parameter int PHYS_W       = ooo_pkg::PHYS_W,
  parameter int ARCH_W       = ooo_pkg::ARCH_W
) (
  input  logic              clk,
  input  logic              reset,
  retire_unit_if.slave      bus,
  input  logic [ARCH_W-1:0] rrat_rd_idx,
  output logic [PHYS_W-1:0] rrat_rd_phys,
  output logic              trace_valid,
  output logic [ARCH_W-1:0] trace_rd,
  output logic [31:0]       trace_value
`ifdef RETIRE_PERF_CNT_EN
  ,
  output logic [31:0]       retired_count,
  output logic [31:0]       free_stall_count
`endif
);

  localparam int ARCH_N = (NUM_ARCH_REGS == (1 << ARCH_W)) ? NUM_ARCH_REGS : (1 << ARCH_W);

  logic [PHYS_W-1:0] rrat [ARCH_N];
  logic              accept;
  logic              push;
  logic              pop;
  logic              q_full;
  logic              q_empty;
  logic [PHYS_W-1:0] q_head;

  // Ready comes only from registered queue occupancy, never from commit_valid.
  assign bus.commit_ready = !q_full;
  assign accept           = bus.commit_valid && bus.commit_ready;
  assign push             = accept && (bus.commit_arch_rd != '0);
  assign pop              = bus.retire_valid && bus.free_ready;

  free_return_fifo #(
    .DEPTH (FREE_Q_DEPTH),
    .WIDTH (PHYS_W)
  ) u_free_q (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (bus.free_oldDest),
    .pop       (pop),
    .full      (q_full),
    .empty     (q_empty),
    .head      (q_head)
  );

  assign bus.retire_valid    = !q_empty;
  assign bus.retire_phys_reg = q_empty ? '0 : q_head;

  // NOTE: sequential state uses non-blocking assignment so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ARCH_N; i++) rrat[i] <= PHYS_W'(i);
    end else if (push) begin
      rrat[bus.commit_arch_rd] <= bus.commit_dest;
    end
  end

  // Read sees state before this cycle's write.
  assign rrat_rd_phys = rrat[rrat_rd_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      trace_valid <= 1'b0;
      trace_rd    <= '0;
      trace_value <= '0;
    end else begin
      trace_valid <= accept;
      if (accept) begin
        trace_rd    <= bus.commit_arch_rd;
        trace_value <= bus.commit_value;
      end
    end
  end

`ifdef RETIRE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_count    <= '0;
      free_stall_count <= '0;
    end else begin
      if (accept)                                retired_count    <= retired_count + 32'd1;
      if (bus.retire_valid && !bus.free_ready)   free_stall_count <= free_stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_retire_unit.sv
// Directed self-checking bench for retire_unit.
module tb_retire_unit;

  localparam int PHYS_W = 6;
  localparam int ARCH_W = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [ARCH_W-1:0] rrat_rd_idx;
  logic [PHYS_W-1:0] rrat_rd_phys;
  logic              trace_valid;
  logic [ARCH_W-1:0] trace_rd;
  logic [31:0]       trace_value;
`ifdef RETIRE_PERF_CNT_EN
  logic [31:0]       retired_count;
  logic [31:0]       free_stall_count;
`endif

  int tests = 0;
  int fails = 0;

  retire_unit_if #(.PHYS_W(PHYS_W), .ARCH_W(ARCH_W)) bus ();

  retire_unit #(
    .FREE_Q_DEPTH (4),
    .PHYS_W       (PHYS_W),
    .ARCH_W       (ARCH_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .rrat_rd_idx  (rrat_rd_idx),
    .rrat_rd_phys (rrat_rd_phys),
    .trace_valid  (trace_valid),
    .trace_rd     (trace_rd),
    .trace_value  (trace_value)
`ifdef RETIRE_PERF_CNT_EN
    ,
    .retired_count    (retired_count),
    .free_stall_count (free_stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int rd, input int dest, input int old, input logic [31:0] val);
    bus.commit_valid   = v;
    bus.commit_arch_rd = ARCH_W'(rd);
    bus.commit_dest    = PHYS_W'(dest);
    bus.free_oldDest   = PHYS_W'(old);
    bus.commit_value   = val;
  endtask

  initial begin
    reset          = 1'b1;
    rrat_rd_idx    = '0;
    bus.free_ready = 1'b0;
    drive(1'b0, 0, 0, 0, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset state
    for (int i = 0; i < 32; i++) begin
      rrat_rd_idx = ARCH_W'(i);
      #1;
      check($sformatf("reset_rrat[%0d]", i), 32'(rrat_rd_phys), 32'(i));
    end
    check("reset_commit_ready", 32'(bus.commit_ready), 32'd1);
    check("reset_retire_valid", 32'(bus.retire_valid), 32'd0);
    check("reset_retire_phys",  32'(bus.retire_phys_reg), 32'd0);
    check("reset_trace_valid",  32'(trace_valid), 32'd0);
    check("reset_trace_rd",     32'(trace_rd), 32'd0);
    check("reset_trace_value",  trace_value, 32'd0);

    // Single commit rd=1 dest=32 old=1
    bus.free_ready = 1'b1;
    rrat_rd_idx    = 5'd1;
    drive(1'b1, 1, 32, 1, 32'hdead_0001);
    #1;
    check("c1_ready", 32'(bus.commit_ready), 32'd1);
    check("c1_rrat_no_bypass", 32'(rrat_rd_phys), 32'd1);
    tick();
    drive(1'b0, 0, 0, 0, 32'h0);
    #1;
    check("c1_rrat1",        32'(rrat_rd_phys), 32'd32);
    check("c1_retire_valid", 32'(bus.retire_valid), 32'd1);
    check("c1_retire_phys",  32'(bus.retire_phys_reg), 32'd1);
    check("c1_trace_valid",  32'(trace_valid), 32'd1);
    check("c1_trace_rd",     32'(trace_rd), 32'd1);
    check("c1_trace_value",  trace_value, 32'hdead_0001);
    tick();
    check("c1_retire_drained", 32'(bus.retire_valid), 32'd0);
    check("c1_trace_idle",     32'(trace_valid), 32'd0);

    // rd=0 commit: trace only
    drive(1'b1, 0, 40, 5, 32'h0000_0040);
    tick();
    drive(1'b0, 0, 0, 0, 32'h0);
    rrat_rd_idx = 5'd0;
    #1;
    check("r0_rrat0",        32'(rrat_rd_phys), 32'd0);
    check("r0_retire_valid", 32'(bus.retire_valid), 32'd0);
    check("r0_trace_valid",  32'(trace_valid), 32'd1);
    check("r0_trace_rd",     32'(trace_rd), 32'd0);
    check("r0_trace_value",  trace_value, 32'h0000_0040);
    tick();

    // Fill with free_ready low, 5th commit stalls
    bus.free_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, k, 32 + k, k, 32'(k));
      #1;
      check($sformatf("fill_ready_%0d", k), 32'(bus.commit_ready), 32'd1);
      tick();
    end
    drive(1'b1, 5, 37, 5, 32'd5);
    #1;
    check("full_ready_low",  32'(bus.commit_ready), 32'd0);
    check("full_head",       32'(bus.retire_phys_reg), 32'd1);
    tick();
    check("full_still_low",  32'(bus.commit_ready), 32'd0);
    check("full_trace_idle", 32'(trace_valid), 32'd0);
    bus.free_ready = 1'b1;
    #1;
    check("full_no_bypass",  32'(bus.commit_ready), 32'd0);
    check("drain_head1",     32'(bus.retire_phys_reg), 32'd1);
    tick();
    check("drain_ready_up",  32'(bus.commit_ready), 32'd1);
    check("drain_head2",     32'(bus.retire_phys_reg), 32'd2);
    tick();
    drive(1'b0, 0, 0, 0, 32'h0);
    #1;
    check("drain_head3",     32'(bus.retire_phys_reg), 32'd3);
    check("c5_trace_valid",  32'(trace_valid), 32'd1);
    check("c5_trace_rd",     32'(trace_rd), 32'd5);
    rrat_rd_idx = 5'd5;
    #1;
    check("c5_rrat5",        32'(rrat_rd_phys), 32'd37);
    tick();
    check("drain_head4",     32'(bus.retire_phys_reg), 32'd4);
    tick();
    check("drain_head5",     32'(bus.retire_phys_reg), 32'd5);
    tick();
    check("drain_empty",     32'(bus.retire_valid), 32'd0);

    // Sustained commit, pointers wrap several times
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 6 + k, 48 + k, 16 + k, 32'(100 + k));
      #1;
      check($sformatf("sus_ready_%0d", k), 32'(bus.commit_ready), 32'd1);
      if (k > 0) begin
        check($sformatf("sus_valid_%0d", k), 32'(bus.retire_valid), 32'd1);
        check($sformatf("sus_phys_%0d", k),  32'(bus.retire_phys_reg), 32'(16 + k - 1));
      end
      tick();
    end
    drive(1'b0, 0, 0, 0, 32'h0);
    rrat_rd_idx = 5'd15;
    #1;
    check("sus_last_phys",  32'(bus.retire_phys_reg), 32'd25);
    check("sus_rrat15",     32'(rrat_rd_phys), 32'd57);
    check("sus_trace_val",  trace_value, 32'd109);
    tick();
    check("sus_empty",      32'(bus.retire_valid), 32'd0);

    // Partial fill then reset mid-operation
    bus.free_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, k, 9 + k, 39 + k, 32'(k));
      tick();
    end
    drive(1'b0, 0, 0, 0, 32'h0);
    rrat_rd_idx = 5'd2;
    #1;
    check("pre_rst_valid", 32'(bus.retire_valid), 32'd1);
    check("pre_rst_head",  32'(bus.retire_phys_reg), 32'd40);
    check("pre_rst_rrat2", 32'(rrat_rd_phys), 32'd11);
`ifdef RETIRE_PERF_CNT_EN
    check("pre_rst_retired", retired_count, 32'd20);
    check("pre_rst_stall",   free_stall_count, 32'd6);
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rst_retire_valid", 32'(bus.retire_valid), 32'd0);
    check("rst_commit_ready", 32'(bus.commit_ready), 32'd1);
    check("rst_trace_valid",  32'(trace_valid), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      rrat_rd_idx = ARCH_W'(i);
      #1;
      check($sformatf("rst_rrat[%0d]", i), 32'(rrat_rd_phys), 32'(i));
    end
`ifdef RETIRE_PERF_CNT_EN
    check("rst_retired", retired_count, 32'd0);
    check("rst_stall",   free_stall_count, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
